// File: rtl/mem_branch_resolve.sv
// MEM-stage branch resolution: combinational PCSrc/next_pc/flush plus
// registered last-taken flag and saturating branch statistics counters.
module mem_branch_resolve #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic              zero,
    input  logic              branch_ne,
    input  logic              valid,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              flush,
    output logic              last_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic cond;
    logic resolved;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // so no latch can be inferred.
    always_comb begin
        cond     = branch_ne ? ~zero : zero;
        resolved = branch & valid;
        PCSrc    = resolved & cond;
        next_pc  = PCSrc ? branch_target : pc_plus4;
        flush    = PCSrc;
    end

    // Reset has priority over a same-edge increment; counters stick at all-ones.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_taken <= 1'b0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            last_taken <= PCSrc;
            if (resolved && branch_cnt != CNT_MAX)
                branch_cnt <= branch_cnt + 1'b1;
            if (PCSrc && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_branch_resolve.sv
// Scoreboard bench for mem_branch_resolve: a default-width instance and a
// CNT_W=4 instance share stimulus; expectations come from a local model.
module tb_mem_branch_resolve;

    logic        clk = 1'b0;
    logic        rst, branch, zero, branch_ne, valid;
    logic [31:0] pc_plus4, branch_target;

    logic        pcsrc_a, flush_a, last_a;
    logic [31:0] npc_a;
    logic [15:0] bcnt_a, tcnt_a;

    logic        pcsrc_b, flush_b, last_b;
    logic [31:0] npc_b;
    logic [3:0]  bcnt_b, tcnt_b;

    typedef struct packed {
        logic        pcsrc;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    logic        m_last;
    logic [15:0] m_bcnt, m_tcnt;
    logic [3:0]  m_bcnt4, m_tcnt4;

    always #5 clk = ~clk;

    mem_branch_resolve dut (
        .clk(clk), .rst(rst), .branch(branch), .zero(zero),
        .branch_ne(branch_ne), .valid(valid), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .PCSrc(pcsrc_a), .next_pc(npc_a),
        .flush(flush_a), .last_taken(last_a), .branch_cnt(bcnt_a),
        .taken_cnt(tcnt_a)
    );

    mem_branch_resolve #(.ADDR_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .branch(branch), .zero(zero),
        .branch_ne(branch_ne), .valid(valid), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .PCSrc(pcsrc_b), .next_pc(npc_b),
        .flush(flush_b), .last_taken(last_b), .branch_cnt(bcnt_b),
        .taken_cnt(tcnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then check state after the edge.
    task automatic step(input logic r, input logic b, input logic z, input logic ne,
                        input logic v, input logic [31:0] pc4, input logic [31:0] tgt);
        logic taken;
        exp_t e;
        @(negedge clk);
        rst = r; branch = b; zero = z; branch_ne = ne; valid = v;
        pc_plus4 = pc4; branch_target = tgt;
        taken = b && v && (ne ? !z : z);
        sb.push_back('{pcsrc: taken, npc: (taken ? tgt : pc4)});
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pcsrc",    {31'd0, pcsrc_a}, {31'd0, e.pcsrc});
            check("flush",    {31'd0, flush_a}, {31'd0, e.pcsrc});
            check("next_pc",  npc_a,            e.npc);
            check("pcsrc4",   {31'd0, pcsrc_b}, {31'd0, e.pcsrc});
            check("next_pc4", npc_b,            e.npc);
        end
        @(posedge clk);
        if (r) begin
            m_last = 1'b0; m_bcnt = '0; m_tcnt = '0; m_bcnt4 = '0; m_tcnt4 = '0;
        end else begin
            m_last = taken;
            if (b && v) begin
                if (m_bcnt  != 16'hFFFF) m_bcnt  = m_bcnt + 16'd1;
                if (m_bcnt4 != 4'hF)     m_bcnt4 = m_bcnt4 + 4'd1;
            end
            if (taken) begin
                if (m_tcnt  != 16'hFFFF) m_tcnt  = m_tcnt + 16'd1;
                if (m_tcnt4 != 4'hF)     m_tcnt4 = m_tcnt4 + 4'd1;
            end
        end
        #1;
        check("last_taken",  {31'd0, last_a}, {31'd0, m_last});
        check("branch_cnt",  {16'd0, bcnt_a}, {16'd0, m_bcnt});
        check("taken_cnt",   {16'd0, tcnt_a}, {16'd0, m_tcnt});
        check("last_taken4", {31'd0, last_b}, {31'd0, m_last});
        check("branch_cnt4", {28'd0, bcnt_b}, {28'd0, m_bcnt4});
        check("taken_cnt4",  {28'd0, tcnt_b}, {28'd0, m_tcnt4});
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; zero = 1'b0; branch_ne = 1'b0; valid = 1'b1;
        pc_plus4 = 32'h0; branch_target = 32'h0;
        m_last = 1'b0; m_bcnt = '0; m_tcnt = '0; m_bcnt4 = '0; m_tcnt4 = '0;

        step(1, 0, 0, 0, 1, 32'h0000_0004, 32'h0000_0100);
        step(1, 0, 0, 0, 1, 32'h0000_0008, 32'h0000_0100);
        check("rst_branch_cnt", {16'd0, bcnt_a}, 32'd0);
        check("rst_last_taken", {31'd0, last_a}, 32'd0);

        // beq walk: not-branch, branch not-zero, taken, branch dropped
        step(0, 0, 0, 0, 1, 32'h0040_0004, 32'h0040_1000);
        step(0, 1, 0, 0, 1, 32'h0040_0008, 32'h0040_1000);
        step(0, 1, 1, 0, 1, 32'h0040_000C, 32'h0040_1000);
        step(0, 0, 1, 0, 1, 32'h0040_1004, 32'h0040_2000);

        // bne semantics
        step(0, 1, 0, 1, 1, 32'h1000_0000, 32'hFFFF_FFFC);
        step(0, 1, 1, 1, 1, 32'h1000_0004, 32'hFFFF_FFFC);

        // bubble: no redirect, counters frozen
        step(0, 1, 1, 0, 0, 32'h2000_0000, 32'h3000_0000);

        // 3 taken + 2 not-taken from reset
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 1, 1, 0, 1, 32'h0000_0010, 32'h0000_0080);
        step(0, 1, 0, 0, 1, 32'h0000_0014, 32'h0000_0080);
        step(0, 1, 1, 0, 1, 32'h0000_0018, 32'h0000_0090);
        step(0, 1, 0, 1, 1, 32'h0000_001C, 32'h0000_00A0);
        step(0, 1, 1, 1, 1, 32'h0000_0020, 32'h0000_00B0);
        check("five_branches", {16'd0, bcnt_a}, 32'd5);
        check("three_taken",   {16'd0, tcnt_a}, 32'd3);

        // saturation of the 4-bit counters
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 0, 1, 32'h0000_1000 + 32'(i * 4), 32'h0000_8000);
        check("sat_branch_cnt4", {28'd0, bcnt_b}, 32'd15);
        check("sat_taken_cnt4",  {28'd0, tcnt_b}, 32'd15);
        check("twenty_branches", {16'd0, bcnt_a}, 32'd20);

        // reset with a live taken branch: PCSrc stays 1, counters clear
        step(1, 1, 1, 0, 1, 32'h0000_2000, 32'h0000_9000);
        check("rst_clear_cnt4", {28'd0, bcnt_b}, 32'd0);

        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), $urandom, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
